// File: rtl/link_pkt_buffer.sv
// Store-and-forward byte-packet buffer: byte RAM plus a length FIFO; only committed packets reach the link.
// Define LINK_PKT_BUFFER_STATS_EN to add the drop_count and hwm statistics outputs.
module link_pkt_buffer #(
   parameter int AW = 11,
   parameter int PW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_stb,
   input  logic          in_end,
   output logic [7:0]    out_data,
   output logic          out_avail,
   input  logic          out_read,
   output logic          out_complete,
   output logic [PW:0]   pkt_pending,
   output logic          overflow
`ifdef LINK_PKT_BUFFER_STATS_EN
   ,
   output logic [7:0]    drop_count,
   output logic [AW:0]   hwm
`endif
);

   localparam int DEPTH = 1 << AW;
   localparam int LDEPTH = 1 << PW;
   localparam logic [AW:0] BYTE_FULL = (AW + 1)'(DEPTH);
   localparam logic [PW:0] SLOT_FULL = (PW + 1)'(LDEPTH);
   localparam logic [AW:0] ONE_A = (AW + 1)'(1);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] len_mem [LDEPTH];

   logic [AW:0]   wptr_reg, cwptr_reg, rptr_reg, plen_reg, rd_cnt_reg;
   logic [PW-1:0] lhead_reg, ltail_reg;
   logic          drop_reg, started_reg;

   logic [AW:0] used, plen_eff, rptr_next;
   logic [PW:0] pend_next;
   logic        byte_full, slot_full, wr_en, drop_eff, any_bytes;
   logic        commit, discard, rd_fire, rd_last, fwd;

   always_comb begin
      used      = wptr_reg - rptr_reg;
      byte_full = (used == BYTE_FULL);
      slot_full = (pkt_pending == SLOT_FULL);
      wr_en     = in_stb && !drop_reg && !byte_full;
      drop_eff  = drop_reg || (in_stb && byte_full);
      plen_eff  = wr_en ? plen_reg + ONE_A : plen_reg;
      any_bytes = started_reg || in_stb;
      commit    = in_end && any_bytes && !drop_eff && !slot_full && (plen_eff != '0);
      discard   = in_end && any_bytes && (drop_eff || slot_full);
      rd_fire   = out_read && out_avail;
      rd_last   = rd_fire && ((rd_cnt_reg + ONE_A) == len_mem[lhead_reg]);
      rptr_next = rd_fire ? rptr_reg + ONE_A : rptr_reg;
      pend_next = pkt_pending + (PW + 1)'(commit) - (PW + 1)'(rd_last);
      // The byte landing this cycle may be the very next one the link needs.
      fwd       = wr_en && (wptr_reg[AW-1:0] == rptr_next[AW-1:0]);
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wptr_reg[AW-1:0]] <= in_data;
      if (commit)
         len_mem[ltail_reg] <= plen_eff;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_reg     <= '0;
         cwptr_reg    <= '0;
         rptr_reg     <= '0;
         plen_reg     <= '0;
         rd_cnt_reg   <= '0;
         lhead_reg    <= '0;
         ltail_reg    <= '0;
         drop_reg     <= 1'b0;
         started_reg  <= 1'b0;
         pkt_pending  <= '0;
         out_avail    <= 1'b0;
         out_complete <= 1'b0;
         out_data     <= '0;
         overflow     <= 1'b0;
      end else begin
         if (discard)
            wptr_reg <= cwptr_reg;
         else if (wr_en)
            wptr_reg <= wptr_reg + ONE_A;
         if (commit) begin
            cwptr_reg <= plen_eff + cwptr_reg;
            ltail_reg <= ltail_reg + 1'b1;
         end
         if (in_end) begin
            plen_reg    <= '0;
            drop_reg    <= 1'b0;
            started_reg <= 1'b0;
         end else begin
            plen_reg    <= plen_eff;
            drop_reg    <= drop_eff;
            started_reg <= any_bytes;
         end
         if (discard)
            overflow <= 1'b1;
         if (rd_last) begin
            rd_cnt_reg <= '0;
            lhead_reg  <= lhead_reg + 1'b1;
         end else if (rd_fire) begin
            rd_cnt_reg <= rd_cnt_reg + ONE_A;
         end
         rptr_reg     <= rptr_next;
         pkt_pending  <= pend_next;
         out_avail    <= (pend_next != '0);
         out_complete <= rd_last;
         out_data     <= fwd ? in_data : mem[rptr_next[AW-1:0]];
      end
   end

`ifdef LINK_PKT_BUFFER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_count <= '0;
         hwm        <= '0;
      end else begin
         if (discard && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         if (used > hwm)
            hwm <= used;
      end
   end
`endif

endmodule

// File: tb/tb_link_pkt_buffer.sv
// Scoreboard bench for link_pkt_buffer with AW=4, PW=1 so byte-full, slot-full and wrap are all reachable.
module tb_link_pkt_buffer;

   localparam int AW = 4;
   localparam int PW = 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    in_data = '0;
   logic          in_stb = 1'b0;
   logic          in_end = 1'b0;
   logic [7:0]    out_data;
   logic          out_avail;
   logic          out_read = 1'b0;
   logic          out_complete;
   logic [PW:0]   pkt_pending;
   logic          overflow;
`ifdef LINK_PKT_BUFFER_STATS_EN
   logic [7:0]    drop_count;
   logic [AW:0]   hwm;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [8:0] exp_q[$];   // {last-byte-of-packet, byte}

   link_pkt_buffer #(.AW(AW), .PW(PW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_stb(in_stb), .in_end(in_end),
      .out_data(out_data), .out_avail(out_avail), .out_read(out_read),
      .out_complete(out_complete), .pkt_pending(pkt_pending), .overflow(overflow)
`ifdef LINK_PKT_BUFFER_STATS_EN
      , .drop_count(drop_count), .hwm(hwm)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      n_cmp++;
      if (out_avail !== 1'b0 || out_complete !== 1'b0 || pkt_pending !== '0 || out_data !== 8'h00) begin
         n_err++;
         $display("FAIL %s: avail=%b complete=%b pending=%0d data=%h, required all zero",
                  tag, out_avail, out_complete, pkt_pending, out_data);
      end
   endtask

   task automatic test_reset();
      in_stb = 0; in_end = 0; out_read = 0;
      rst_n = 0;
      #1;
      check_idle("reset_outputs");
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++; $display("FAIL reset_overflow: got %b required 0", overflow);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1;
      exp_q.delete();
      tick();
      $display("reset done");
   endtask

   task automatic send(input int n, input logic [7:0] base, input logic [7:0] step, input bit accept);
      logic [7:0] d;
      for (int i = 0; i < n; i++) begin
         d = base + 8'(i * step);
         in_data = d; in_stb = 1; in_end = (i == n - 1);
         if (accept) exp_q.push_back({(i == n - 1), d});
         tick();
      end
      in_stb = 0; in_end = 0;
      $display("send %0d bytes from %02h accept=%0b pending=%0d overflow=%0b", n, base, accept, pkt_pending, overflow);
   endtask

   task automatic drain(input int n, input string tag);
      logic [8:0] e;
      for (int i = 0; i < n; i++) begin
         if (exp_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s_scoreboard: got empty queue required %0d more bytes", tag, n - i);
            break;
         end
         e = exp_q.pop_front();
         n_cmp++;
         if (out_avail !== 1'b1) begin
            n_err++; $display("FAIL %s_avail: got %b required 1", tag, out_avail);
         end
         n_cmp++;
         if (out_data !== e[7:0]) begin
            n_err++; $display("FAIL %s_data: got %h required %h", tag, out_data, e[7:0]);
         end
         out_read = 1;
         tick();
         n_cmp++;
         if (out_complete !== e[8]) begin
            n_err++; $display("FAIL %s_complete: got %b required %b", tag, out_complete, e[8]);
         end
         $display("%s read %02h last=%0b", tag, e[7:0], e[8]);
      end
      out_read = 0;
   endtask

   task automatic test_basic();
      send(4, 8'h11, 8'h11, 1);
      n_cmp++;
      if (out_avail !== 1'b1 || pkt_pending !== 2'd1) begin
         n_err++; $display("FAIL basic_commit: avail=%b pending=%0d required 1/1", out_avail, pkt_pending);
      end
      drain(4, "basic");
      tick();
      n_cmp++;
      if (out_complete !== 1'b0 || out_avail !== 1'b0 || pkt_pending !== '0) begin
         n_err++; $display("FAIL basic_after: complete=%b avail=%b pending=%0d required 0/0/0",
                           out_complete, out_avail, pkt_pending);
      end
   endtask

   task automatic test_back_to_back();
      send(3, 8'h30, 8'h01, 1);
      send(5, 8'h50, 8'h01, 1);
      n_cmp++;
      if (pkt_pending !== 2'd2) begin
         n_err++; $display("FAIL b2b_pending: got %0d required 2", pkt_pending);
      end
      drain(8, "b2b");
      n_cmp++;
      if (out_avail !== 1'b0) begin
         n_err++; $display("FAIL b2b_empty: got avail=%b required 0", out_avail);
      end
   endtask

   task automatic test_byte_overflow();
      send(10, 8'h60, 8'h01, 1);
      send(7, 8'h80, 8'h01, 0);
      n_cmp++;
      if (overflow !== 1'b1 || pkt_pending !== 2'd1) begin
         n_err++; $display("FAIL ovf_state: overflow=%b pending=%0d required 1/1", overflow, pkt_pending);
      end
      drain(10, "ovf");
      tick();
      send(6, 8'h90, 8'h01, 1);
      drain(6, "ovf_after");
   endtask

   task automatic test_slot_full();
      test_reset();
      send(1, 8'hA1, 8'h00, 1);
      send(1, 8'hA2, 8'h00, 1);
      n_cmp++;
      if (overflow !== 1'b0) begin
         n_err++; $display("FAIL slot_pre_overflow: got %b required 0", overflow);
      end
      send(1, 8'hA3, 8'h00, 0);
      n_cmp++;
      if (overflow !== 1'b1 || pkt_pending !== 2'd2) begin
         n_err++; $display("FAIL slot_drop: overflow=%b pending=%0d required 1/2", overflow, pkt_pending);
      end
      drain(2, "slot");
      tick();
      n_cmp++;
      if (out_avail !== 1'b0) begin
         n_err++; $display("FAIL slot_empty: got avail=%b required 0", out_avail);
      end
`ifdef LINK_PKT_BUFFER_STATS_EN
      n_cmp++;
      if (drop_count !== 8'd1 || hwm !== 5'd2) begin
         n_err++; $display("FAIL slot_stats: drop_count=%0d hwm=%0d required 1/2", drop_count, hwm);
      end
`endif
   endtask

   task automatic test_wrap();
      test_reset();
      send(12, 8'hB0, 8'h01, 1);
      drain(12, "wrap_a");
      tick();
      send(9, 8'hC0, 8'h03, 1);
      drain(9, "wrap_b");
      tick();
      in_end = 1;
      tick();
      in_end = 0;
      tick();
      n_cmp++;
      if (pkt_pending !== '0 || out_avail !== 1'b0 || overflow !== 1'b0) begin
         n_err++; $display("FAIL empty_commit: pending=%0d avail=%b overflow=%b required 0/0/0",
                           pkt_pending, out_avail, overflow);
      end
      out_read = 1;
      tick();
      out_read = 0;
      tick();
      n_cmp++;
      if (pkt_pending !== '0 || out_complete !== 1'b0) begin
         n_err++; $display("FAIL empty_read: pending=%0d complete=%b required 0/0", pkt_pending, out_complete);
      end
      send(2, 8'hE0, 8'h01, 1);
      drain(2, "wrap_c");
   endtask

   task automatic test_commit_and_pop();
      logic [8:0] e;
      tick();
      send(1, 8'hD1, 8'h00, 1);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_data !== e[7:0]) begin
         n_err++; $display("FAIL cp_head: got %h required %h", out_data, e[7:0]);
      end
      out_read = 1; in_data = 8'hD2; in_stb = 1; in_end = 1;
      exp_q.push_back({1'b1, 8'hD2});
      tick();
      out_read = 0; in_stb = 0; in_end = 0;
      n_cmp++;
      if (pkt_pending !== 2'd1 || out_complete !== 1'b1 || out_avail !== 1'b1) begin
         n_err++; $display("FAIL cp_state: pending=%0d complete=%b avail=%b required 1/1/1",
                           pkt_pending, out_complete, out_avail);
      end
      $display("commit+pop read %02h", e[7:0]);
      drain(1, "cp");
   endtask

   task automatic test_mid_reset();
      in_data = 8'hF1; in_stb = 1;
      tick();
      in_data = 8'hF2;
      tick();
      rst_n = 0;
      #1;
      check_idle("midwrite_reset");
      in_stb = 0;
      tick();
      rst_n = 1;
      tick();
      send(3, 8'h21, 8'h01, 1);
      out_read = 1;
      tick();
      out_read = 0;
      rst_n = 0;
      #1;
      check_idle("midread_reset");
      exp_q.delete();
      tick();
      rst_n = 1;
      tick();
      n_cmp++;
      if (out_complete !== 1'b0 || overflow !== 1'b0) begin
         n_err++; $display("FAIL midread_after: complete=%b overflow=%b required 0/0", out_complete, overflow);
      end
      send(2, 8'h41, 8'h01, 1);
      drain(2, "fresh");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_byte_overflow();
      test_slot_full();
      test_wrap();
      test_commit_and_pop();
      test_mid_reset();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
